usb_ep_in_packetizer: RTL and testbench

//  Bulk IN endpoint source for the USB device controller's user TX port.
//  App pushes a byte stream (valid/ready); the block buffers it, cuts it into packets
//  of at most MAX_PKT bytes and serves txdat/txpop/txpktfin for endpoint EP_NUM.

---
 rtl/usb_ep_in_packetizer.sv | 149 ++++++++++++++
 tb/tb_usb_ep_in_packetizer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_in_packetizer.sv
// rtl/usb_ep_in_packetizer.sv - bulk IN endpoint packetizer with speculative pop and replay.
// Optional zero-length-packet termination: define USB_EP_ZLP_EN.
module usb_ep_in_packetizer #(
  parameter int EP_NUM  = 1,
  parameter int MAX_PKT = 512,
  parameter int AW      = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    app_data_i,
  input  logic          app_valid_i,
  output logic          app_ready_o,
  input  logic          app_flush_i,
  input  logic [3:0]    endpt_i,
  input  logic          txact_i,
  input  logic          txpop_i,
  input  logic          txpktfin_i,
  output logic [7:0]    txdat_o,
  output logic          txval_o,
  output logic [11:0]   txdat_len_o,
  output logic          txcork_o,
  output logic [AW:0]   level_o,
  output logic          underrun_o
);

  localparam int              PW    = AW + 1;
  localparam logic [PW-1:0]   MAX_P = PW'(MAX_PKT);
  localparam logic [PW-1:0]   ONE   = PW'(1);
  localparam logic [3:0]      EP    = 4'(EP_NUM);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;

  logic [7:0]    mem [2**AW];
  logic [PW-1:0] wr_ptr, rd_ptr, base_ptr, len_q, level, pkt_end;
  logic          cork_q, sel, sel_q, flush_pend, zlp_pend, underrun_q;
  logic          wr_en, pop_ok, commit, replay, offer, drained;

  assign level       = wr_ptr - base_ptr;
  assign app_ready_o = ~level[AW];
  assign wr_en       = app_valid_i & app_ready_o;
  assign sel         = txact_i & (endpt_i == EP);
  assign pkt_end     = base_ptr + len_q;
  assign pop_ok      = (state_q == SEND) & sel & txpop_i & (rd_ptr != pkt_end) & (rd_ptr != wr_ptr);
  assign commit      = (state_q == SEND) & txpktfin_i & (endpt_i == EP);
  // Commit has priority over the transaction ending in the same cycle.
  assign replay      = (state_q == SEND) & ~sel & ~commit;
  assign offer       = (level >= MAX_P) | (flush_pend & (level != '0)) | zlp_pend;
  assign drained     = (rd_ptr == wr_ptr) & ~wr_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel && !sel_q && !cork_q) state_d = SEND;
      SEND:    if (commit || replay) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= app_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      base_ptr   <= '0;
      len_q      <= '0;
      cork_q     <= 1'b1;
      sel_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel;
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (txpop_i && sel && (rd_ptr == wr_ptr)) underrun_q <= 1'b1;
      if (commit) begin
        base_ptr <= rd_ptr;
        cork_q   <= 1'b1;
      end else if (replay) begin
        rd_ptr <= base_ptr;
        cork_q <= 1'b1;
      end else if (pop_ok) begin
        rd_ptr <= rd_ptr + ONE;
      end
      // The offer is re-evaluated only while corked, so an offered length never moves.
      if (state_q == IDLE && cork_q) begin
        cork_q <= ~offer;
        len_q  <= zlp_pend ? '0 : ((level >= MAX_P) ? MAX_P : level);
      end
    end
  end

`ifdef USB_EP_ZLP_EN
  logic zlp_q, last_full;
  assign zlp_pend = zlp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_pend <= 1'b0;
      zlp_q      <= 1'b0;
      last_full  <= 1'b0;
    end else begin
      if (commit) begin
        last_full <= (len_q == MAX_P);
        if (zlp_q) begin
          zlp_q      <= 1'b0;
          flush_pend <= 1'b0;
        end else if (len_q != MAX_P) begin
          flush_pend <= 1'b0;
        end else if (flush_pend && drained) begin
          zlp_q <= 1'b1;
        end
      end
      // A flush on an empty FIFO after a full packet still needs a ZLP to end the transfer.
      if (app_flush_i && !zlp_q) begin
        if (level != '0) begin
          flush_pend <= 1'b1;
        end else if (last_full) begin
          flush_pend <= 1'b1;
          zlp_q      <= 1'b1;
        end
      end
    end
  end
`else
  assign zlp_pend = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_pend <= 1'b0;
    end else if (app_flush_i && level != '0) begin
      flush_pend <= 1'b1;
    end else if (commit && (len_q != MAX_P || drained)) begin
      flush_pend <= 1'b0;
    end
  end
`endif

  assign txcork_o    = cork_q;
  assign txdat_len_o = 12'(len_q);
  assign txval_o     = (state_q == SEND) & sel & (rd_ptr != pkt_end);
  assign txdat_o     = (state_q == SEND) ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign level_o     = level;
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_usb_ep_in_packetizer.sv
// tb/tb_usb_ep_in_packetizer.sv - self-checking bench for usb_ep_in_packetizer.
// Byte-queue reference model; honours USB_EP_ZLP_EN like the design.
module tb_usb_ep_in_packetizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  app_data = 8'h00;
  logic        app_valid = 1'b0;
  logic        app_flush = 1'b0;
  logic [3:0]  endpt = 4'd0;
  logic        txact = 1'b0;
  logic        txpop = 1'b0;
  logic        txpktfin = 1'b0;
  logic        app_ready, txval, txcork, underrun;
  logic [7:0]  txdat;
  logic [11:0] txlen;
  logic [11:0] level;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q[$];

  usb_ep_in_packetizer #(.EP_NUM(1), .MAX_PKT(512), .AW(11)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .app_data_i(app_data), .app_valid_i(app_valid), .app_ready_o(app_ready),
    .app_flush_i(app_flush), .endpt_i(endpt), .txact_i(txact),
    .txpop_i(txpop), .txpktfin_i(txpktfin),
    .txdat_o(txdat), .txval_o(txval), .txdat_len_o(txlen),
    .txcork_o(txcork), .level_o(level), .underrun_o(underrun)
  );

  always #8 clk = ~clk;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic int model_len();
    return (q.size() >= 512) ? 512 : q.size();
  endfunction

  task automatic push_burst(input int n, input bit pattern);
    for (int i = 0; i < n; i++) begin
      app_data  = pattern ? 8'(i) : 8'($urandom);
      app_valid = 1'b1;
      if (q.size() < 2048) q.push_back(app_data);
      @(negedge clk);
    end
    app_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    app_flush = 1'b1;
    @(negedge clk);
    app_flush = 1'b0;
  endtask

  // Host-controller behaviour: wait for an offer, pop npop bytes, then ACK or abandon.
  task automatic serve(input int exp_len, input int npop, input bit do_fin, input int extra);
    int guard = 0;
    while (txcork === 1'b1 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (txcork !== 1'b0) begin
      errors++;
      $display("FAIL serve_offer: txcork=%b after %0d cycles, required 0", txcork, guard);
      return;
    end
    checks++;
    if (txlen !== 12'(exp_len)) begin
      errors++;
      $display("FAIL serve_len: txdat_len=%0d, required %0d", txlen, exp_len);
    end
    endpt = 4'd1;
    txact = 1'b1;
    @(negedge clk);
    for (int i = 0; i < npop; i++) begin
      checks++;
      if (txval !== 1'b1 || txdat !== q[i]) begin
        errors++;
        $display("FAIL serve_data[%0d]: txval=%b txdat=%h, required 1 %h", i, txval, txdat, q[i]);
      end
      txpop = 1'b1;
      @(negedge clk);
      txpop = 1'b0;
    end
    checks++;
    if (txval !== (npop < exp_len)) begin
      errors++;
      $display("FAIL serve_val_end: txval=%b, required %b", txval, npop < exp_len);
    end
    for (int i = 0; i < extra; i++) begin
      txpop = 1'b1;
      @(negedge clk);
      txpop = 1'b0;
      checks++;
      if (txval !== 1'b0) begin
        errors++;
        $display("FAIL serve_extra_pop: txval=%b, required 0", txval);
      end
    end
    if (do_fin) begin
      txpktfin = 1'b1;
      @(negedge clk);
      txpktfin = 1'b0;
      txact = 1'b0;
      repeat (exp_len) void'(q.pop_front());
    end else begin
      txact = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 7;
    if (app_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: %b, required 1", app_ready); end
    if (txcork !== 1'b1) begin errors++; $display("FAIL reset_cork: %b, required 1", txcork); end
    if (txval !== 1'b0) begin errors++; $display("FAIL reset_val: %b, required 0", txval); end
    if (txlen !== 12'd0) begin errors++; $display("FAIL reset_len: %0d, required 0", txlen); end
    if (txdat !== 8'h00) begin errors++; $display("FAIL reset_dat: %h, required 00", txdat); end
    if (level !== 12'd0) begin errors++; $display("FAIL reset_level: %0d, required 0", level); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: %b, required 0", underrun); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_packets();
    push_burst(511, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (txcork !== 1'b1) begin errors++; $display("FAIL full_511_cork: %b, required 1", txcork); end
    app_data = 8'hFF;
    app_valid = 1'b1;
    q.push_back(app_data);
    @(negedge clk);
    app_valid = 1'b0;
    checks++;
    if (txcork !== 1'b1) begin errors++; $display("FAIL latency_1: cork=%b, required 1", txcork); end
    @(negedge clk);
    checks++;
    if (txcork !== 1'b0 || txlen !== 12'd512) begin
      errors++;
      $display("FAIL latency_2: cork=%b len=%0d, required 0 512", txcork, txlen);
    end
    push_burst(512, 1'b1);
    checks++;
    if (level !== 12'(q.size())) begin errors++; $display("FAIL full_level_1024: %0d, required %0d", level, q.size()); end
    serve(model_len(), 512, 1'b1, 0);
    checks++;
    if (level !== 12'(q.size())) begin errors++; $display("FAIL full_level_512: %0d, required %0d", level, q.size()); end
    serve(model_len(), 512, 1'b1, 0);
    checks++;
    if (level !== 12'd0) begin errors++; $display("FAIL full_level_0: %0d, required 0", level); end
  endtask

  task automatic test_flush();
    int bad = 0;
    push_burst(100, 1'b0);
    repeat (1000) begin
      @(negedge clk);
      if (txcork !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL flush_hold_cork: cork low on %0d cycles, required 0", bad); end
    pulse_flush();
    serve(model_len(), model_len(), 1'b1, 0);
    push_burst(10, 1'b0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (txcork !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL flush_cleared: cork low on %0d cycles, required 0", bad); end
    pulse_flush();
    serve(model_len(), model_len(), 1'b1, 0);
  endtask

  task automatic test_replay();
    push_burst(512, 1'b0);
    serve(model_len(), 300, 1'b0, 0);
    checks++;
    if (level !== 12'd512) begin errors++; $display("FAIL replay_level: %0d, required 512", level); end
    serve(model_len(), 512, 1'b1, 0);
    checks++;
    if (level !== 12'd0) begin errors++; $display("FAIL replay_drain: %0d, required 0", level); end
  endtask

  task automatic test_fifo_full();
    int bad = 0;
    for (int i = 0; i < 2100; i++) begin
      app_data = 8'($urandom);
      app_valid = 1'b1;
      if (app_ready !== (q.size() < 2048)) bad++;
      if (q.size() < 2048) q.push_back(app_data);
      @(negedge clk);
    end
    app_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_ready: %0d cycles wrong, required 0", bad); end
    checks++;
    if (app_ready !== 1'b0 || level !== 12'd2048) begin
      errors++;
      $display("FAIL fill_full: ready=%b level=%0d, required 0 2048", app_ready, level);
    end
    serve(model_len(), 512, 1'b1, 2);
    checks++;
    if (app_ready !== 1'b1 || level !== 12'd1536) begin
      errors++;
      $display("FAIL fill_after_commit: ready=%b level=%0d, required 1 1536", app_ready, level);
    end
    while (q.size() > 0) serve(model_len(), model_len(), 1'b1, 0);
  endtask

  task automatic test_zlp();
    int bad = 0;
    push_burst(512, 1'b0);
    pulse_flush();
    serve(model_len(), 512, 1'b1, 0);
`ifdef USB_EP_ZLP_EN
    serve(0, 0, 1'b1, 0);
`endif
    repeat (20) begin
      @(negedge clk);
      if (txcork !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || level !== 12'd0) begin
      errors++;
      $display("FAIL zlp_end: cork low %0d cycles level=%0d, required 0 0", bad, level);
    end
  endtask

  task automatic test_underrun();
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_pre: %b, required 0", underrun); end
    endpt = 4'd1;
    txact = 1'b1;
    txpop = 1'b1;
    @(negedge clk);
    txpop = 1'b0;
    txact = 1'b0;
    @(negedge clk);
    checks++;
    if (underrun !== 1'b1 || level !== 12'd0) begin
      errors++;
      $display("FAIL underrun_set: underrun=%b level=%0d, required 1 0", underrun, level);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int bad = 0;
    push_burst(300, 1'b0);
    pulse_flush();
    while (txcork === 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    endpt = 4'd1;
    txact = 1'b1;
    @(negedge clk);
    txpop = 1'b1;
    repeat (50) @(negedge clk);
    txpop = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 7;
    if (app_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: %b, required 1", app_ready); end
    if (txcork !== 1'b1) begin errors++; $display("FAIL rmid_cork: %b, required 1", txcork); end
    if (txval !== 1'b0) begin errors++; $display("FAIL rmid_val: %b, required 0", txval); end
    if (txlen !== 12'd0) begin errors++; $display("FAIL rmid_len: %0d, required 0", txlen); end
    if (txdat !== 8'h00) begin errors++; $display("FAIL rmid_dat: %h, required 00", txdat); end
    if (level !== 12'd0) begin errors++; $display("FAIL rmid_level: %0d, required 0", level); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL rmid_underrun: %b, required 0", underrun); end
    txact = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    push_burst(20, 1'b0);
    pulse_flush();
    repeat (3) @(negedge clk);
    endpt = 4'd2;
    txact = 1'b1;
    txpop = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (txval !== 1'b0) bad++;
    end
    txpop = 1'b0;
    txact = 1'b0;
    endpt = 4'd1;
    @(negedge clk);
    checks++;
    if (bad != 0 || underrun !== 1'b0 || level !== 12'd20) begin
      errors++;
      $display("FAIL other_ep: val_cycles=%0d underrun=%b level=%0d, required 0 0 20", bad, underrun, level);
    end
    serve(model_len(), model_len(), 1'b1, 0);
    checks++;
    if (level !== 12'd0) begin errors++; $display("FAIL other_ep_drain: %0d, required 0", level); end
  endtask

  initial begin
    test_reset();
    test_full_packets();
    test_flush();
    test_replay();
    test_fifo_full();
    test_zlp();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
